// File: rtl/lvt_read_select_pkg.sv
// Shared types for the LVT read-return path: the bank select field and the
// per-request pipeline record carried by every read lane.
package lvt_pkg;

  localparam int LVT_P      = 4;
  localparam int LVT_DATA_W = 32;

  // Width of one LVT select field; a single-bank table still needs one bit.
  function automatic int calc_n_pe_bits(input int ports);
    return (ports <= 1) ? 1 : $clog2(ports);
  endfunction

  localparam int LVT_N_PE_BITS = calc_n_pe_bits(LVT_P);

  typedef logic [LVT_N_PE_BITS-1:0] bank_id_t;

  typedef struct packed {
    logic                  valid;
    logic                  fwd;
    bank_id_t              sel;
    logic [LVT_DATA_W-1:0] data;
  } rd_pipe_t;

endpackage

// File: rtl/lvt_read_select_lane.sv
// One read port: same-cycle write forwarding, fixed-latency request pipeline
// and the final bank/forward mux into the registered output.
module lvt_read_lane
  import lvt_pkg::*;
#(
  parameter int p           = LVT_P,
  parameter int data_width  = LVT_DATA_W,
  parameter int index_width = 8,
  parameter int rd_lat      = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ren,
  input  logic [index_width-1:0]     raddr,
  input  logic [p-1:0]               wen,
  input  logic [p*index_width-1:0]   waddr,
  input  logic [p*data_width-1:0]    wdata,
  input  bank_id_t                   lvt_sel,
  input  logic [p*data_width-1:0]    bank_rdata,
  output logic [data_width-1:0]      rdata,
  output logic                       rvalid,
  output logic                       fwd_hit
);

  rd_pipe_t              pipe_q [rd_lat];
  rd_pipe_t              pipe_d [rd_lat];
  rd_pipe_t              head;
  logic [data_width-1:0] sel_data;
  logic [data_width-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  fwd_q, fwd_d;

  // Scan from the highest write port down so the lowest matching port wins.
  always_comb begin
    pipe_d[0]       = '0;
    pipe_d[0].valid = ren;
    for (int k = p - 1; k >= 0; k--) begin
      if (ren && wen[k] && (waddr[k*index_width +: index_width] == raddr)) begin
        pipe_d[0].fwd  = 1'b1;
        pipe_d[0].data = wdata[k*data_width +: data_width];
      end
    end
    for (int s = 1; s < rd_lat; s++) begin
      pipe_d[s] = pipe_q[s-1];
      if (s == 1) pipe_d[s].sel = lvt_sel;
    end
  end

  // With a one-cycle bank the LVT select arrives together with the bank data.
  always_comb begin
    head = pipe_q[rd_lat-1];
    if (rd_lat == 1) head.sel = lvt_sel;
    sel_data = bank_rdata[int'(head.sel)*data_width +: data_width];
    rdata_d  = rdata_q;
    if (head.valid) rdata_d = head.fwd ? head.data : sel_data;
    rvalid_d = head.valid;
    fwd_d    = head.valid & head.fwd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < rd_lat; s++) pipe_q[s] <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      fwd_q    <= 1'b0;
    end else begin
      for (int s = 0; s < rd_lat; s++) pipe_q[s] <= pipe_d[s];
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      fwd_q    <= fwd_d;
    end
  end

  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;
  assign fwd_hit = fwd_q;

endmodule

// File: rtl/lvt_read_select.sv
// Read-return stage behind the LVT hash memory: one lvt_read_lane per read
// port, the top level only slices the flat buses.
module lvt_read_select
  import lvt_pkg::*;
#(
  parameter int p           = LVT_P,
  parameter int data_width  = LVT_DATA_W,
  parameter int index_width = 8,
  parameter int n_PE_bits   = 2,
  parameter int rd_lat      = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [p-1:0]                  ren,
  input  logic [p*index_width-1:0]      raddr,
  input  logic [p-1:0]                  wen,
  input  logic [p*index_width-1:0]      waddr,
  input  logic [p*data_width-1:0]       wdata,
  input  logic [p*n_PE_bits-1:0]        lvt_sel,
  input  logic [p*p*data_width-1:0]     bank_rdata,
  output logic [p*data_width-1:0]       rdata,
  output logic [p-1:0]                  rvalid,
  output logic [p-1:0]                  fwd_hit
);

  if ((p < 2) || ((p & (p - 1)) != 0)) begin : g_bad_p
    $error("lvt_read_select: p must be a power of two >= 2");
  end
  if (n_PE_bits != $clog2(p)) begin : g_bad_sel
    $error("lvt_read_select: n_PE_bits must equal clog2(p)");
  end
  if ((p != LVT_P) || (data_width != LVT_DATA_W)) begin : g_bad_pkg
    $error("lvt_read_select: p/data_width must match lvt_pkg");
  end
  if (rd_lat < 1) begin : g_bad_lat
    $error("lvt_read_select: rd_lat must be >= 1");
  end

  // rvalid is a one-cycle strobe with no ready: the consumer must take
  // rdata/fwd_hit in the cycle rvalid is high; rdata holds otherwise.
  for (genvar i = 0; i < p; i++) begin : g_lane
    lvt_read_lane #(
      .p           (p),
      .data_width  (data_width),
      .index_width (index_width),
      .rd_lat      (rd_lat)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .ren        (ren[i]),
      .raddr      (raddr[i*index_width +: index_width]),
      .wen        (wen),
      .waddr      (waddr),
      .wdata      (wdata),
      .lvt_sel    (bank_id_t'(lvt_sel[i*n_PE_bits +: n_PE_bits])),
      .bank_rdata (bank_rdata[i*p*data_width +: p*data_width]),
      .rdata      (rdata[i*data_width +: data_width]),
      .rvalid     (rvalid[i]),
      .fwd_hit    (fwd_hit[i])
    );
  end

endmodule

// File: tb/tb_lvt_read_select.sv
// Directed bench for lvt_read_select with rd_lat=2: reset, basic read,
// forwarding priority, write-after-read, throughput and mid-flight reset.
module tb_lvt_read_select;

  localparam int P  = 4;
  localparam int DW = 32;
  localparam int IW = 8;
  localparam int NB = 2;
  localparam int RL = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [P-1:0]          ren;
  logic [P*IW-1:0]       raddr;
  logic [P-1:0]          wen;
  logic [P*IW-1:0]       waddr;
  logic [P*DW-1:0]       wdata;
  logic [P*NB-1:0]       lvt_sel;
  logic [P*P*DW-1:0]     bank_rdata;
  logic [P*DW-1:0]       rdata;
  logic [P-1:0]          rvalid;
  logic [P-1:0]          fwd_hit;

  int total = 0;
  int bad   = 0;

  logic [DW:0] exp_q[$];

  lvt_read_select #(
    .p(P), .data_width(DW), .index_width(IW), .n_PE_bits(NB), .rd_lat(RL)
  ) dut (
    .clk(clk), .reset(reset), .ren(ren), .raddr(raddr), .wen(wen),
    .waddr(waddr), .wdata(wdata), .lvt_sel(lvt_sel), .bank_rdata(bank_rdata),
    .rdata(rdata), .rvalid(rvalid), .fwd_hit(fwd_hit)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    ren = '0; raddr = '0; wen = '0; waddr = '0; wdata = '0;
    lvt_sel = '0; bank_rdata = '0;
  endtask

  task automatic set_bank(input int i, input int k, input logic [DW-1:0] v);
    bank_rdata[(i*P+k)*DW +: DW] = v;
  endtask

  function automatic logic [DW-1:0] rd(input int i);
    return rdata[i*DW +: DW];
  endfunction

  task automatic test_reset;
    idle_inputs();
    reset = 1'b1;
    ren   = '1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (rvalid !== '0 || rdata !== '0 || fwd_hit !== '0) begin
        bad++;
        $display("FAIL reset_hold c=%0d rvalid=%b fwd=%b rdata=%h want 0", c, rvalid, fwd_hit, rdata);
      end
    end
    reset = 1'b0;
    ren   = '0;
    for (int c = 0; c < RL + 1; c++) begin
      tick();
      total++;
      if (rvalid !== '0 || rdata !== '0 || fwd_hit !== '0) begin
        bad++;
        $display("FAIL reset_after c=%0d rvalid=%b fwd=%b rdata=%h want 0", c, rvalid, fwd_hit, rdata);
      end
    end
  endtask

  task automatic test_basic_read;
    idle_inputs();
    ren[1] = 1'b1; raddr[1*IW +: IW] = 8'h10;
    tick();
    idle_inputs();
    lvt_sel[1*NB +: NB] = 2'd2;
    lvt_sel[0*NB +: NB] = 2'd3;
    tick();
    total++;
    if (rvalid !== '0) begin
      bad++; $display("FAIL basic_early rvalid=%b want 0000", rvalid);
    end
    idle_inputs();
    set_bank(1, 0, 32'h0BAD0000); set_bank(1, 1, 32'h0BAD0001);
    set_bank(1, 2, 32'hCAFE0001); set_bank(1, 3, 32'h0BAD0003);
    set_bank(0, 2, 32'h12345678);
    tick();
    total++;
    if (rvalid !== 4'b0010 || rd(1) !== 32'hCAFE0001 || fwd_hit !== '0) begin
      bad++;
      $display("FAIL basic_read rvalid=%b rdata1=%h fwd=%b want 0010 cafe0001 0000", rvalid, rd(1), fwd_hit);
    end
    idle_inputs();
    tick();
    total++;
    if (rvalid !== '0 || rd(1) !== 32'hCAFE0001) begin
      bad++;
      $display("FAIL basic_hold rvalid=%b rdata1=%h want 0000 cafe0001", rvalid, rd(1));
    end
  endtask

  task automatic test_forward_priority;
    idle_inputs();
    ren[0] = 1'b1; raddr[0*IW +: IW] = 8'h20;
    wen = 4'b1110;
    waddr[1*IW +: IW] = 8'h20; wdata[1*DW +: DW] = 32'h11;
    waddr[2*IW +: IW] = 8'h21; wdata[2*DW +: DW] = 32'h22;
    waddr[3*IW +: IW] = 8'h20; wdata[3*DW +: DW] = 32'h33;
    tick();
    // second read one cycle later: only port 3 write matches
    idle_inputs();
    lvt_sel[0*NB +: NB] = 2'd1;
    ren[0] = 1'b1; raddr[0*IW +: IW] = 8'h40;
    wen = 4'b1001;
    waddr[0*IW +: IW] = 8'h41; wdata[0*DW +: DW] = 32'hAA;
    waddr[3*IW +: IW] = 8'h40; wdata[3*DW +: DW] = 32'h44;
    tick();
    idle_inputs();
    for (int k = 0; k < P; k++) set_bank(0, k, 32'hBEEF0000 + k);
    lvt_sel[0*NB +: NB] = 2'd2;
    tick();
    total++;
    if (rvalid !== 4'b0001 || rd(0) !== 32'h11 || fwd_hit !== 4'b0001) begin
      bad++;
      $display("FAIL fwd_lowest rvalid=%b rdata0=%h fwd=%b want 0001 00000011 0001", rvalid, rd(0), fwd_hit);
    end
    idle_inputs();
    for (int k = 0; k < P; k++) set_bank(0, k, 32'hBEEF1000 + k);
    tick();
    total++;
    if (rvalid !== 4'b0001 || rd(0) !== 32'h44 || fwd_hit !== 4'b0001) begin
      bad++;
      $display("FAIL fwd_single rvalid=%b rdata0=%h fwd=%b want 0001 00000044 0001", rvalid, rd(0), fwd_hit);
    end
  endtask

  task automatic test_write_after_read;
    idle_inputs();
    ren[2] = 1'b1; raddr[2*IW +: IW] = 8'h05;
    tick();
    idle_inputs();
    wen[0] = 1'b1; waddr[0*IW +: IW] = 8'h05; wdata[0*DW +: DW] = 32'hDEAD;
    lvt_sel[2*NB +: NB] = 2'd3;
    tick();
    idle_inputs();
    set_bank(2, 0, 32'h0000DEAD); set_bank(2, 3, 32'h5555AAAA);
    tick();
    total++;
    if (rvalid !== 4'b0100 || rd(2) !== 32'h5555AAAA || fwd_hit !== '0) begin
      bad++;
      $display("FAIL war rvalid=%b rdata2=%h fwd=%b want 0100 5555aaaa 0000", rvalid, rd(2), fwd_hit);
    end
  endtask

  task automatic test_write_only;
    idle_inputs();
    wen = '1;
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < P; k++) begin
        waddr[k*IW +: IW] = IW'(c);
        raddr[k*IW +: IW] = IW'(c);
        wdata[k*DW +: DW] = 32'hF00 + c;
      end
      tick();
      if (c >= RL + 1) begin
        total++;
        if (rvalid !== '0 || fwd_hit !== '0) begin
          bad++; $display("FAIL write_only c=%0d rvalid=%b fwd=%b want 0000", c, rvalid, fwd_hit);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [IW-1:0] ra [24][P];
    logic [IW-1:0] wa [24][P];
    logic [DW-1:0] wd [24][P];
    logic [P-1:0]  we [24];
    logic [NB-1:0] sl [24][P];
    logic [DW-1:0] bk [24][P][P];
    logic [DW:0]   e;
    logic          found;
    for (int c = 0; c < 24; c++) begin
      we[c] = 4'($urandom_range(0, 15));
      for (int i = 0; i < P; i++) begin
        ra[c][i] = IW'($urandom_range(0, 7));
        wa[c][i] = IW'($urandom_range(0, 7));
        wd[c][i] = $urandom;
        sl[c][i] = NB'($urandom_range(0, 3));
        for (int k = 0; k < P; k++) bk[c][i][k] = $urandom;
      end
    end
    exp_q.delete();
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < P; i++) begin
        found = 1'b0;
        e = '0;
        for (int k = 0; k < P; k++) begin
          if (!found && we[r][k] && wa[r][k] == ra[r][i]) begin
            found = 1'b1;
            e = {1'b1, wd[r][k]};
          end
        end
        if (!found) e = {1'b0, bk[r+2][i][sl[r+1][i]]};
        exp_q.push_back(e);
      end
    end
    for (int c = 0; c < 24; c++) begin
      if (c >= 3 && c < 23) begin
        for (int i = 0; i < P; i++) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL b2b_queue c=%0d port=%0d queue empty", c, i);
          end else begin
            e = exp_q.pop_front();
            if (rvalid[i] !== 1'b1 || rd(i) !== e[DW-1:0] || fwd_hit[i] !== e[DW]) begin
              bad++;
              $display("FAIL b2b c=%0d port=%0d rvalid=%b rdata=%h fwd=%b want 1 %h %b",
                       c, i, rvalid[i], rd(i), fwd_hit[i], e[DW-1:0], e[DW]);
            end
          end
        end
      end
      if (c == 23) begin
        total++;
        if (rvalid !== '0 || exp_q.size() != 0) begin
          bad++; $display("FAIL b2b_tail rvalid=%b left=%0d want 0000 0", rvalid, exp_q.size());
        end
      end
      idle_inputs();
      if (c < 20) begin
        ren = '1;
        wen = we[c];
      end
      for (int i = 0; i < P; i++) begin
        raddr[i*IW +: IW]   = ra[c][i];
        waddr[i*IW +: IW]   = wa[c][i];
        wdata[i*DW +: DW]   = wd[c][i];
        lvt_sel[i*NB +: NB] = sl[c][i];
        for (int k = 0; k < P; k++) set_bank(i, k, bk[c][i][k]);
      end
      tick();
    end
  endtask

  task automatic test_reset_midflight;
    idle_inputs();
    ren[3] = 1'b1; raddr[3*IW +: IW] = 8'h33;
    tick();
    idle_inputs();
    reset = 1'b1;
    lvt_sel[3*NB +: NB] = 2'd1;
    tick();
    reset = 1'b0;
    set_bank(3, 1, 32'h99);
    tick();
    total++;
    if (rvalid !== '0 || rd(3) !== '0) begin
      bad++; $display("FAIL midflight_drop rvalid=%b rdata3=%h want 0000 0", rvalid, rd(3));
    end
    idle_inputs();
    tick();
    total++;
    if (rvalid !== '0) begin
      bad++; $display("FAIL midflight_quiet rvalid=%b want 0000", rvalid);
    end
    ren[3] = 1'b1; raddr[3*IW +: IW] = 8'h34;
    tick();
    idle_inputs();
    lvt_sel[3*NB +: NB] = 2'd1;
    tick();
    idle_inputs();
    set_bank(3, 1, 32'h77); set_bank(3, 0, 32'h66);
    tick();
    total++;
    if (rvalid !== 4'b1000 || rd(3) !== 32'h77 || fwd_hit !== '0) begin
      bad++;
      $display("FAIL midflight_new rvalid=%b rdata3=%h fwd=%b want 1000 00000077 0000", rvalid, rd(3), fwd_hit);
    end
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_basic_read();
    test_forward_priority();
    test_write_after_read();
    test_write_only();
    test_back_to_back();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
